// File: rtl/ram8_16bit.sv
// rtl/ram8_16bit.sv - 8x16 synchronous single-port RAM, registered read, optional RAM8_16BIT_BYPASS_EN write-first forwarding
module ram8_16bit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] add,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_do_write;
    logic                  w_do_read;

    // Strobes only count when the chip is enabled.
    assign w_do_write = en & write;
    assign w_do_read  = en & read;

    // Select the data captured into the output register on a read.
`ifdef RAM8_16BIT_BYPASS_EN
    always_comb begin
        w_rd_data = r_mem[add];
        if (write) begin
            w_rd_data = in;
        end
    end
`else
    always_comb begin
        w_rd_data = r_mem[add];
    end
`endif

    // Storage array: cleared by reset, written on an enabled write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_write) begin
            r_mem[add] <= in;
        end
    end

    // Output register: cleared by reset, loaded on an enabled read, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if (w_do_read) begin
            r_out <= w_rd_data;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_ram8_16bit.sv
// tb/tb_ram8_16bit.sv - randomized self-checking bench for ram8_16bit against an array model
module tb_ram8_16bit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        read;
    logic        write;
    logic [2:0]  add;
    logic [15:0] in;
    logic [15:0] out;

    logic [15:0] m_mem [8];
    logic [15:0] m_out;
    int          n_checks;
    int          n_fails;

`ifdef RAM8_16BIT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    ram8_16bit dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .read  (read),
        .write (write),
        .add   (add),
        .in    (in),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle(input logic r, input logic e, input logic rd, input logic wr,
                         input logic [2:0] a, input logic [15:0] d);
        logic [15:0] old;
        @(negedge clk);
        rst = r; en = e; read = rd; write = wr; add = a; in = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 16'd0;
            m_out = 16'd0;
        end else if (e) begin
            old = m_mem[a];
            if (wr) m_mem[a] = d;
            if (rd) m_out = (BYPASS && wr) ? d : old;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        for (int a = 0; a < 8; a++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'(a), 16'hffff);
            n_checks++;
            if (out !== 16'd0) begin
                n_fails++;
                $display("FAIL reset_clear add=%0d out=%h required=%h", a, out, 16'd0);
            end
        end
    endtask

    task automatic test_fill();
        logic [15:0] req;
        for (int a = 0; a < 8; a++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'(a), 16'(a + 1));
            req = BYPASS ? 16'(a + 1) : 16'd0;
            n_checks++;
            if (out !== req || out !== m_out) begin
                n_fails++;
                $display("FAIL fill add=%0d out=%h required=%h", a, out, req);
            end
        end
    endtask

    task automatic test_disable();
        logic [15:0] held;
        held = m_out;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'd9);
        n_checks++;
        if (out !== held) begin
            n_fails++;
            $display("FAIL disable_hold out=%h required=%h", out, held);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'hxxxx);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 16'd0);
        n_checks++;
        if (out !== 16'd6) begin
            n_fails++;
            $display("FAIL disable_mem5 out=%h required=%h", out, 16'd6);
        end
    endtask

    task automatic test_read_first();
        logic [15:0] req;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 16'd10);
        req = BYPASS ? 16'd10 : 16'd5;
        n_checks++;
        if (out !== req) begin
            n_fails++;
            $display("FAIL rdw_same_addr out=%h required=%h", out, req);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 16'd0);
        n_checks++;
        if (out !== 16'd10) begin
            n_fails++;
            $display("FAIL read_after_write out=%h required=%h", out, 16'd10);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'd0);
        n_checks++;
        if (out !== 16'd10) begin
            n_fails++;
            $display("FAIL no_read_hold out=%h required=%h", out, 16'd10);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 16'h1234);
        n_checks++;
        if (out !== 16'd0) begin
            n_fails++;
            $display("FAIL reset_mid_out out=%h required=%h", out, 16'd0);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 16'd0);
        n_checks++;
        if (out !== 16'd0) begin
            n_fails++;
            $display("FAIL reset_mid_mem7 out=%h required=%h", out, 16'd0);
        end
    endtask

    task automatic test_random();
        logic r, e, rd, wr;
        logic [2:0]  a;
        logic [15:0] d;
        for (int n = 0; n < 300; n++) begin
            r  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 3) != 0);
            rd = $urandom_range(0, 1);
            wr = $urandom_range(0, 1);
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            cycle(r, e, rd, wr, a, d);
            n_checks++;
            if (out !== m_out) begin
                n_fails++;
                $display("FAIL random n=%0d rst=%b en=%b rd=%b wr=%b add=%0d in=%h out=%h required=%h",
                         n, r, e, rd, wr, a, d, out, m_out);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1; en = 1'b0; read = 1'b0; write = 1'b0; add = 3'd0; in = 16'd0;
        for (int i = 0; i < 8; i++) m_mem[i] = 16'd0;
        m_out = 16'd0;
        test_reset();
        test_fill();
        test_disable();
        test_read_first();
        test_reset();
        test_fill();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
